stopwatch_core: RTL
===================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter: DIV, 1_000_000, clk cycles per 10 ms hundredth tick (legal DIV >= 2).
REQ-002 SHALL have port: clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: btn_ss  input  1  start/stop request, debounced level.
REQ-005 SHALL have port: btn_clr  input  1  clear request, debounced level.
REQ-006 SHALL have port: btn_lap  input  1  lap freeze request, debounced level.
REQ-007 SHALL have ports: hex0..hex5  output  4 each  BCD display digits; hex1:hex0 hundredths, hex3:hex2 seconds, hex5:hex4 minutes (feeds 6-digit display driver, dots after hex4 and hex2).
REQ-008 SHALL have port: running  output  1  high in RUN state.
REQ-009 SHALL have port: wrap  output  1  one-cycle pulse on 59:59.99 -> 00:00.00 rollover.

Function
REQ-010 SHALL register each btn input and detect rising edges (btn high, previous sample low); an edge acts in the cycle after the rising sample, one action per edge; held levels produce no repeats.
REQ-011 SHALL implement states IDLE, RUN, PAUSE: IDLE --ss--> RUN; RUN --ss--> PAUSE; PAUSE --ss--> RUN; any state --clr--> IDLE.
REQ-012 SHALL run the divider counter (0..DIV-1) only in RUN; it holds its value in PAUSE and is cleared in IDLE.
REQ-013 SHALL issue one internal tick per DIV RUN cycles, on the cycle the divider reaches DIV-1; the divider then returns to 0.
REQ-014 SHALL, on tick, increment the time value: hundredths 0-99, seconds 0-59, minutes 0-59, each BCD digit 0-9 with carry to the next field.
REQ-015 SHALL, on tick at 59:59.99, set time to 00:00.00, assert wrap for exactly that cycle and remain in RUN.
REQ-016 SHALL give the time value one-cycle latency: outputs reflect the increment on the cycle after the tick.
REQ-017 SHALL never hold an out-of-range BCD digit (A-F) in any register.
REQ-018 SHALL give clear priority: clr edge together with ss or lap edge in the same cycle gives IDLE with 00:00.00, divider 0 and freeze released.
REQ-019 SHALL assert running only in RUN; wrap SHALL be 0 outside the rollover cycle.

Reset
REQ-020 SHALL, with rst_n low at a clock edge, set state IDLE, time 00:00.00, divider 0, edge-detect history 0, freeze released, all hex outputs 0, running 0, wrap 0.
REQ-021 SHALL let reset asserted mid-RUN override all button edges in the same cycle; no tick or wrap in that cycle.
REQ-022 SHALL, when rst_n is released with a btn input already high, not treat it as an edge (history was reset to 0, so a rising edge requires a low-to-high transition).

Configuration
REQ-023 SHALL support macro STOPWATCH_LAP_EN; when defined, a btn_lap edge in RUN copies the current time into a snapshot register and hex outputs show the snapshot while counting continues; the next lap edge (RUN or PAUSE) releases freeze and outputs show live time.
REQ-024 SHALL, with STOPWATCH_LAP_EN defined, ignore a lap edge in IDLE, and in PAUSE act only to release an active freeze.
REQ-025 SHALL, without STOPWATCH_LAP_EN, ignore btn_lap, include no snapshot register, and drive hex outputs from live time always.

Verification (bench DIV=4)
REQ-026 SHALL verify count: reset, ss edge, run 400 clk -> outputs 00:01.00, running=1.
REQ-027 SHALL verify pause: ss, 40 clk, ss, wait 100 clk -> outputs hold 00:00.10; ss again, 2 more ticks -> 00:00.12, with the partial divider count kept.
REQ-028 SHALL verify rollover: RUN from 59:59.98, 2 ticks -> 00:00.00, wrap high exactly 1 cycle, running=1.
REQ-029 SHALL verify priority: clr and ss edges in the same cycle during RUN -> IDLE, 00:00.00, running=0.
REQ-030 SHALL verify lap (STOPWATCH_LAP_EN defined): lap edge at 00:00.05, 20 ticks -> outputs 00:00.05; lap edge -> outputs 00:00.25.
REQ-031 SHALL verify reset mid-RUN: rst_n low one cycle at 00:03.47 with btn_ss held high -> 00:00.00, IDLE, no start until btn_ss goes low then high.

Source files
------------

// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
//
// Start/stop/clear stopwatch counting MM:SS.hh in BCD, with an optional lap
// freeze. A divider turns DIV clock cycles into one 10 ms hundredth tick; the
// tick advances the six-digit BCD time value, which wraps from 59:59.99 to
// 00:00.00.
//
// Build option:
//   STOPWATCH_LAP_EN  defined   -> btn_lap freezes the display on a snapshot
//                                  of the time while counting continues; the
//                                  next lap edge releases the freeze.
//                     undefined -> btn_lap is ignored, no snapshot register,
//                                  the display always shows live time.
//
// Parameters:
//   DIV      clk cycles per hundredth tick (DIV >= 2)
//
// Ports:
//   clk      clock, all logic on the rising edge
//   rst_n    synchronous active-low reset
//   btn_ss   start/stop request (debounced level)
//   btn_clr  clear request (debounced level)
//   btn_lap  lap freeze/release request (debounced level)
//   hex0-1   hundredths digits (units, tens)
//   hex2-3   seconds digits (units, tens)
//   hex4-5   minutes digits (units, tens)
//   running  high while counting (RUN state)
//   wrap     one-cycle pulse when the time rolls over 59:59.99 -> 00:00.00
// -----------------------------------------------------------------------------
module stopwatch_core #(
  parameter int unsigned DIV = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       btn_lap,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] hex4,
  output logic [3:0] hex5,
  output logic       running,
  output logic       wrap
);

  localparam int unsigned      DIV_W    = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  // Field order matches the display: minutes tens on hex5 down to
  // hundredths units on hex0.
  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic [3:0] hun_t;
    logic [3:0] hun_u;
  } bcd_time_t;

  // ---------------------------------------------------------------------------
  // Button edge detection
  // ---------------------------------------------------------------------------
`ifdef STOPWATCH_LAP_EN
  localparam int NB = 3;
  logic [NB-1:0] btn_in;
  assign btn_in = {btn_lap, btn_clr, btn_ss};
`else
  localparam int NB = 2;
  logic [NB-1:0] btn_in;
  logic          unused_btn_lap;
  assign btn_in         = {btn_clr, btn_ss};
  assign unused_btn_lap = btn_lap;
`endif

  logic [NB-1:0] btn_s_q;   // registered button sample
  logic [NB-1:0] btn_h_q;   // previous sample (history)
  logic          primed_q;  // first post-reset sample has been taken
  logic [NB-1:0] btn_rise;
  logic          ss_rise;
  logic          clr_rise;

  // The first sample after reset also seeds the history with the same level,
  // so a button already held high when reset is released does not count as a
  // press; a real press needs a low-to-high transition afterwards.
  // NOTE: clocked state uses non-blocking (<=) assignments so every register
  // samples the pre-edge values regardless of statement or block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s_q  <= '0;
      btn_h_q  <= '0;
      primed_q <= 1'b0;
    end else begin
      btn_s_q  <= btn_in;
      btn_h_q  <= primed_q ? btn_s_q : btn_in;
      primed_q <= 1'b1;
    end
  end

  assign btn_rise = btn_s_q & ~btn_h_q;
  assign ss_rise  = btn_rise[0];
  assign clr_rise = btn_rise[1];

  // ---------------------------------------------------------------------------
  // BCD increment
  // ---------------------------------------------------------------------------
  // Returns {carry_out, next_digit}. Anything at or above the field limit
  // wraps to 0, so a digit can never step into A-F.
  function automatic logic [4:0] bump(input logic [3:0] d,
                                      input logic [3:0] last,
                                      input logic       cin);
    if (!cin)       return {1'b0, d};
    if (d >= last)  return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  bcd_time_t        live_q;
  bcd_time_t        live_inc;
  logic             tick;
  logic             c_hu, c_ht, c_su, c_st, c_mu, c_mt;

  // NOTE: every always_comb output gets a default before any conditional
  // logic, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    live_inc = live_q;
    c_hu     = 1'b0;
    c_ht     = 1'b0;
    c_su     = 1'b0;
    c_st     = 1'b0;
    c_mu     = 1'b0;
    c_mt     = 1'b0;
    {c_hu, live_inc.hun_u} = bump(live_q.hun_u, 4'd9, 1'b1);
    {c_ht, live_inc.hun_t} = bump(live_q.hun_t, 4'd9, c_hu);
    {c_su, live_inc.sec_u} = bump(live_q.sec_u, 4'd9, c_ht);
    {c_st, live_inc.sec_t} = bump(live_q.sec_t, 4'd5, c_su);
    {c_mu, live_inc.min_u} = bump(live_q.min_u, 4'd9, c_st);
    {c_mt, live_inc.min_t} = bump(live_q.min_t, 4'd5, c_mu);
  end

  // One tick per DIV RUN cycles, on the cycle the divider sits at DIV-1.
  assign tick = (state_q == S_RUN) && (div_q == DIV_LAST);

  // ---------------------------------------------------------------------------
  // Control FSM, divider and live time
  // ---------------------------------------------------------------------------
  // Clear outranks start/stop; reset outranks everything, including a tick
  // due in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      running <= 1'b0;
      wrap    <= 1'b0;
      div_q   <= '0;
      live_q  <= '0;
    end else begin
      wrap <= 1'b0;
      if (clr_rise) begin
        state_q <= S_IDLE;
        running <= 1'b0;
        div_q   <= '0;
        live_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            div_q <= '0;
            if (ss_rise) begin
              state_q <= S_RUN;
              running <= 1'b1;
            end
          end
          S_RUN: begin
            if (tick) begin
              div_q  <= '0;
              live_q <= live_inc;
              wrap   <= c_mt;   // all fields carried: 59:59.99 -> 00:00.00
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
            if (ss_rise) begin
              state_q <= S_PAUSE;
              running <= 1'b0;
            end
          end
          S_PAUSE: begin
            // Divider and time hold, keeping any partial hundredth.
            if (ss_rise) begin
              state_q <= S_RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            running <= 1'b0;
            div_q   <= '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display source
  // ---------------------------------------------------------------------------
  bcd_time_t shown;

`ifdef STOPWATCH_LAP_EN
  logic      lap_rise;
  logic      frozen_q;
  logic      lap_capture;
  bcd_time_t snap_q;

  assign lap_rise = btn_rise[2];

  // A lap edge in RUN with no freeze active takes a snapshot; any lap edge
  // while frozen releases. IDLE is never frozen (reset and clear release).
  assign lap_capture = lap_rise && !clr_rise && !frozen_q && (state_q == S_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frozen_q <= 1'b0;
    end else if (clr_rise) begin
      frozen_q <= 1'b0;
    end else if (lap_rise && frozen_q) begin
      frozen_q <= 1'b0;
    end else if (lap_capture) begin
      frozen_q <= 1'b1;
    end
  end

  // NOTE: the snapshot is a plain data register with no reset; it is only
  // ever displayed while frozen_q is set, and frozen_q is set in the same
  // edge that loads it.
  always_ff @(posedge clk) begin
    if (lap_capture) begin
      snap_q <= live_q;
    end
  end

  assign shown = frozen_q ? snap_q : live_q;
`else
  assign shown = live_q;
`endif

  assign {hex5, hex4, hex3, hex2, hex1, hex0} = shown;

endmodule
